mc_control32: RTL



---
 rtl/mc_control32.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mc_control32.sv
// Multicycle MIPS-style control FSM (IF/ID/EX/MEM/WB) with combinational decode and a bus watchdog.
// Latency: strobes are combinational from the current state and inputs; the state advances on each rising clock edge.
// Backpressure: IF and MEM stall until Mem_ready; after MAX_WAIT idle cycles they raise Bus_err and return to IF.
// Ports: clock, reset (async, active-low); Opcode/Function_opcode/Alu_resultHigh/Zero/Mem_ready in;
//        State, write strobes, bus request levels, decode levels, ALUOp, PCSrc and status pulses out.
module mc_control32 #(
  parameter int unsigned          ADDR_HI_W = 22,
  parameter logic [ADDR_HI_W-1:0] IO_HI     = '1,
  parameter int unsigned          MAX_WAIT  = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Function_opcode,
  input  logic [ADDR_HI_W-1:0] Alu_resultHigh,
  input  logic                 Zero,
  input  logic                 Mem_ready,
  output logic [2:0]           State,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 InstrRead,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IORead,
  output logic                 IOWrite,
  output logic                 RegDST,
  output logic                 ALUSrc,
  output logic                 MemIOtoReg,
  output logic                 Sftmd,
  output logic                 Jrn,
  output logic                 Jal,
  output logic                 Jmp,
  output logic                 I_format,
  output logic [1:0]           ALUOp,
  output logic [1:0]           PCSrc,
  output logic                 Instr_done,
  output logic                 Bus_err,
  output logic                 Illegal
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  // Instruction decode
  logic r_fmt, is_jr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, legal;
  logic io_sel, timeout, taken;

  assign r_fmt    = (Opcode == 6'b000000);
  assign is_jr    = r_fmt && (Function_opcode == 6'b001000);
  assign I_format = (Opcode[5:3] == 3'b001);
  assign is_lw    = (Opcode == 6'b100011);
  assign is_sw    = (Opcode == 6'b101011);
  assign is_beq   = (Opcode == 6'b000100);
  assign is_bne   = (Opcode == 6'b000101);
  assign is_j     = (Opcode == 6'b000010);
  assign is_jal   = (Opcode == 6'b000011);
  assign legal    = r_fmt | I_format | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;

  assign Sftmd      = r_fmt && (Function_opcode[5:3] == 3'b000);
  assign ALUSrc     = I_format | is_lw | is_sw;
  assign RegDST     = r_fmt;
  assign MemIOtoReg = is_lw;
  assign Jrn        = is_jr;
  assign Jal        = is_jal;
  assign Jmp        = is_j;
  assign ALUOp      = {r_fmt | I_format, is_beq | is_bne};

  assign io_sel  = (Alu_resultHigh == IO_HI);
  assign taken   = (is_beq & Zero) | (is_bne & ~Zero);
  // Mem_ready in the same cycle as the timeout wins, so timeout is qualified with ~Mem_ready.
  assign timeout = (wait_q == CNT_W'(MAX_WAIT)) & ~Mem_ready;

  assign State = state_q;

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;   // any cycle that is not a stall clears the counter
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    InstrRead  = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IORead     = 1'b0;
    IOWrite    = 1'b0;
    PCSrc      = 2'd0;
    Instr_done = 1'b0;
    Bus_err    = 1'b0;
    Illegal    = 1'b0;
    // Outputs are gated by reset so every strobe drops the instant reset asserts.
    if (reset) begin
      case (state_q)
        S_IF: begin
          InstrRead = 1'b1;
          if (Mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_ID;
          end else if (timeout) begin
            Bus_err = 1'b1;
            state_d = S_IF;
          end else begin
            wait_d = wait_q + CNT_W'(1);
          end
        end
        S_ID: begin
          if (!legal) begin
            Illegal = 1'b1;
            state_d = S_IF;
          end else if (is_j || is_jal) begin
            PCWrite    = 1'b1;
            PCSrc      = 2'd2;
            RegWrite   = is_jal;
            Instr_done = 1'b1;
            state_d    = S_IF;
          end else begin
            state_d = S_EX;
          end
        end
        S_EX: begin
          if (is_beq || is_bne) begin
            PCWrite    = taken;
            PCSrc      = taken ? 2'd1 : 2'd0;
            Instr_done = 1'b1;
            state_d    = S_IF;
          end else if (is_jr) begin
            PCWrite    = 1'b1;
            PCSrc      = 2'd3;
            Instr_done = 1'b1;
            state_d    = S_IF;
          end else if (is_lw || is_sw) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          IORead   = is_lw &  io_sel;
          MemRead  = is_lw & ~io_sel;
          IOWrite  = is_sw &  io_sel;
          MemWrite = is_sw & ~io_sel;
          if (Mem_ready) begin
            Instr_done = is_sw;
            state_d    = is_lw ? S_WB : S_IF;
          end else if (timeout) begin
            Bus_err = 1'b1;
            state_d = S_IF;
          end else begin
            wait_d = wait_q + CNT_W'(1);
          end
        end
        S_WB: begin
          RegWrite   = 1'b1;
          Instr_done = 1'b1;
          state_d    = S_IF;
        end
        default: state_d = S_IF;  // unreachable encodings recover silently
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule
